ex_stage: RTL

Execute stage of the 5-stage pipelined RISC-V core, sitting directly downstream of the ID/EX pipeline register and feeding the MEM stage.
- Selects ALU operands, resolving forwarding from its own EX/MEM register and from MEM/WB.
- Executes single-cycle ALU and branch-compare ops, and runs an iterative 32-cycle multiply/divide engine that stalls the front end.
- Registers results and the WB/MEM control bits into the EX/MEM pipeline register.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/ex_stage_if.sv | 57 +++++
 rtl/muldiv_iter.sv | 77 +++++++
 rtl/ex_stage.sv | 126 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU opcodes and
// the multiply/divide FSM state type.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_SLL   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_SLT   = 5'd8;
  localparam logic [4:0] ALU_SLTU  = 5'd9;
  localparam logic [4:0] ALU_MUL   = 5'd10;
  localparam logic [4:0] ALU_DIVU  = 5'd11;
  localparam logic [4:0] ALU_REMU  = 5'd12;
  localparam logic [4:0] ALU_BEQ   = 5'd13;
  localparam logic [4:0] ALU_BNE   = 5'd14;
  localparam logic [4:0] ALU_PASSB = 5'd15;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_t;

  function automatic logic is_md_op(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, MEM/WB forwarding source and EX/MEM outputs of the execute
// stage; the slave side is the stage itself, the master side its environment.
interface ex_stage_if;
  import cpu_pkg::*;

  logic            id_ex_valid;
  logic [XLEN-1:0] id_ex_pc;
  logic [XLEN-1:0] read1_data;
  logic [XLEN-1:0] read2_data;
  logic [63:0]     imm;
  logic [4:0]      id_ex_rs1;
  logic [4:0]      id_ex_rs2;
  logic [4:0]      id_ex_rd;
  logic            RegWrite;
  logic            MemtoReg;
  logic            MemWrite;
  logic            MemRead;
  logic            Branch;
  logic            ALUSrc;
  logic [4:0]      ALUOp;
  logic            wb_regwrite;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            ex_busy;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            ex_mem_valid;
  logic            ex_mem_RegWrite;
  logic            ex_mem_MemtoReg;
  logic            ex_mem_MemWrite;
  logic            ex_mem_MemRead;
  logic [XLEN-1:0] ex_mem_alu_result;
  logic [XLEN-1:0] ex_mem_store_data;
  logic [4:0]      ex_mem_rd;

  modport master (
    output id_ex_valid, id_ex_pc, read1_data, read2_data, imm,
           id_ex_rs1, id_ex_rs2, id_ex_rd,
           RegWrite, MemtoReg, MemWrite, MemRead, Branch, ALUSrc, ALUOp,
           wb_regwrite, wb_rd, wb_data,
    input  ex_busy, branch_taken, branch_target,
           ex_mem_valid, ex_mem_RegWrite, ex_mem_MemtoReg, ex_mem_MemWrite,
           ex_mem_MemRead, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd
  );

  modport slave (
    input  id_ex_valid, id_ex_pc, read1_data, read2_data, imm,
           id_ex_rs1, id_ex_rs2, id_ex_rd,
           RegWrite, MemtoReg, MemWrite, MemRead, Branch, ALUSrc, ALUOp,
           wb_regwrite, wb_rd, wb_data,
    output ex_busy, branch_taken, branch_target,
           ex_mem_valid, ex_mem_RegWrite, ex_mem_MemtoReg, ex_mem_MemWrite,
           ex_mem_MemRead, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd
  );

endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiplier / restoring divider, one step per cycle.
// Result is held combinationally while the FSM sits in DONE.
module muldiv_iter
  import cpu_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(MD_CYCLES);

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       op_p0;
  logic [XLEN-1:0]  opa_p0, opb_p0, acc_p0;
  logic [XLEN:0]    rem_shift;
  logic             rem_ge;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == MD_BUSY) cnt <= cnt + CNT_W'(1);
      else                  cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (start) state_nxt = MD_BUSY;
      MD_BUSY: if (cnt == CNT_W'(MD_CYCLES - 1)) state_nxt = MD_DONE;
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // opa: multiplicand (mul) or dividend shifting into quotient (div); acc: product or remainder
  always_comb begin
    rem_shift = {acc_p0, opa_p0[XLEN-1]};
    rem_ge    = rem_shift >= {1'b0, opb_p0};
  end

  always_ff @(posedge clk) begin
    if (state == MD_IDLE && start) begin
      op_p0  <= op;
      opa_p0 <= a;
      opb_p0 <= b;
      acc_p0 <= '0;
    end else if (state == MD_BUSY) begin
      if (op_p0 == ALU_MUL) begin
        if (opb_p0[0]) acc_p0 <= acc_p0 + opa_p0;
        opa_p0 <= opa_p0 << 1;
        opb_p0 <= opb_p0 >> 1;
      end else begin
        acc_p0 <= rem_ge ? XLEN'(rem_shift - {1'b0, opb_p0}) : rem_shift[XLEN-1:0];
        opa_p0 <= {opa_p0[XLEN-2:0], rem_ge};
      end
    end
  end

  assign busy   = (state == MD_BUSY);
  assign done   = (state == MD_DONE);
  assign result = (op_p0 == ALU_DIVU) ? opa_p0 : acc_p0;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU and branch compare,
// iterative mul/div with front-end stall, and the EX/MEM pipeline register.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave ifc
);

  logic [XLEN-1:0]        fwd_a, fwd_b, op_b, md_result, alu_res_p0;
  logic signed [XLEN-1:0] a_s, b_s;
  logic                   exm_fwd_ok, wb_fwd_ok, md_start, md_busy, md_done;
  logic                   br_cond, busy, unused_imm_hi;

  logic                   vld_p1, regwrite_p1, memtoreg_p1, memwrite_p1, memread_p1;
  logic [XLEN-1:0]        result_p1, store_p1;
  logic [4:0]             rd_p1;

  assign unused_imm_hi = ^ifc.imm[63:XLEN];

  // Load results are not yet available in EX/MEM, so they never forward from there
  assign exm_fwd_ok = vld_p1 && regwrite_p1 && (rd_p1 != 5'd0) && !memread_p1;
  assign wb_fwd_ok  = ifc.wb_regwrite && (ifc.wb_rd != 5'd0);

  always_comb begin
    fwd_a = ifc.read1_data;
    if (exm_fwd_ok && rd_p1 == ifc.id_ex_rs1)            fwd_a = result_p1;
    else if (wb_fwd_ok && ifc.wb_rd == ifc.id_ex_rs1)    fwd_a = ifc.wb_data;
    fwd_b = ifc.read2_data;
    if (exm_fwd_ok && rd_p1 == ifc.id_ex_rs2)            fwd_b = result_p1;
    else if (wb_fwd_ok && ifc.wb_rd == ifc.id_ex_rs2)    fwd_b = ifc.wb_data;
  end

  assign op_b = ifc.ALUSrc ? ifc.imm[XLEN-1:0] : fwd_b;
  assign a_s  = $signed(fwd_a);
  assign b_s  = $signed(op_b);

  // Only an idle engine accepts an op; in DONE the held instruction is the one completing
  assign md_start = rst && ifc.id_ex_valid && is_md_op(ifc.ALUOp) && !md_busy && !md_done;
  assign busy     = rst && (md_start || md_busy);

  muldiv_iter #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .op     (ifc.ALUOp),
    .a      (fwd_a),
    .b      (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    alu_res_p0 = '0;
    case (ifc.ALUOp)
      ALU_ADD:   alu_res_p0 = fwd_a + op_b;
      ALU_SUB:   alu_res_p0 = fwd_a - op_b;
      ALU_AND:   alu_res_p0 = fwd_a & op_b;
      ALU_OR:    alu_res_p0 = fwd_a | op_b;
      ALU_XOR:   alu_res_p0 = fwd_a ^ op_b;
      ALU_SLL:   alu_res_p0 = fwd_a << op_b[4:0];
      ALU_SRL:   alu_res_p0 = fwd_a >> op_b[4:0];
      ALU_SRA:   alu_res_p0 = a_s >>> op_b[4:0];
      ALU_SLT:   alu_res_p0 = {{(XLEN-1){1'b0}}, a_s < b_s};
      ALU_SLTU:  alu_res_p0 = {{(XLEN-1){1'b0}}, fwd_a < op_b};
      ALU_MUL,
      ALU_DIVU,
      ALU_REMU:  alu_res_p0 = md_result;
      ALU_PASSB: alu_res_p0 = op_b;
      default:   alu_res_p0 = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    if (ifc.ALUOp == ALU_BEQ)      br_cond = (fwd_a == fwd_b);
    else if (ifc.ALUOp == ALU_BNE) br_cond = (fwd_a != fwd_b);
  end

  assign ifc.ex_busy       = busy;
  assign ifc.branch_taken  = rst && ifc.id_ex_valid && ifc.Branch && !busy && br_cond;
  assign ifc.branch_target = rst ? ifc.id_ex_pc + ifc.imm[XLEN-1:0] : '0;

  // EX/MEM boundary: bubble while stalled, data held so a stall leaves no glitch downstream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
      memtoreg_p1 <= 1'b0;
      memwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      result_p1   <= '0;
      store_p1    <= '0;
      rd_p1       <= '0;
    end else if (busy) begin
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
      memtoreg_p1 <= 1'b0;
      memwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
    end else begin
      vld_p1      <= ifc.id_ex_valid;
      regwrite_p1 <= ifc.id_ex_valid && ifc.RegWrite;
      memtoreg_p1 <= ifc.id_ex_valid && ifc.MemtoReg;
      memwrite_p1 <= ifc.id_ex_valid && ifc.MemWrite;
      memread_p1  <= ifc.id_ex_valid && ifc.MemRead;
      result_p1   <= alu_res_p0;
      store_p1    <= fwd_b;
      rd_p1       <= ifc.id_ex_rd;
    end
  end

  assign ifc.ex_mem_valid      = vld_p1;
  assign ifc.ex_mem_RegWrite   = regwrite_p1;
  assign ifc.ex_mem_MemtoReg   = memtoreg_p1;
  assign ifc.ex_mem_MemWrite   = memwrite_p1;
  assign ifc.ex_mem_MemRead    = memread_p1;
  assign ifc.ex_mem_alu_result = result_p1;
  assign ifc.ex_mem_store_data = store_p1;
  assign ifc.ex_mem_rd         = rd_p1;

endmodule
